lc3_mem_if: RTL and testbench

LC3_MEM_IF -- requirements
Module: lc3_mem_if

---
 rtl/lc3_pkg.sv | 23 ++
 rtl/lc3_mmio.sv | 79 +++++++
 rtl/lc3_mem_if.sv | 151 +++++++++++++++
 tb/tb_lc3_mem_if.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// LC-3 memory interface shared types: FSM states and memory-mapped device addresses.
// Latency: none; this file holds declarations only.
// Backpressure: none; the decode helper is purely combinational.
package lc3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;

  // Only the four device registers are decoded; the rest of xFE00 page stays external.
  function automatic logic is_mmio(input logic [15:0] addr);
    return (addr == ADDR_KBSR) || (addr == ADDR_KBDR) ||
           (addr == ADDR_DSR)  || (addr == ADDR_DDR);
  endfunction

endpackage

// File: rtl/lc3_mmio.sv
// LC-3 keyboard/display device registers (KBSR, KBDR, DSR, DDR).
// Latency: read data is combinational from MAR; register updates and the DDR strobe take one edge.
// Backpressure: none; each access is taken in the single cycle acc_i is high.
module lc3_mmio
  import lc3_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        acc_i,
  input  logic        we_i,
  input  logic [15:0] addr_i,
  input  logic [15:0] mdr_i,
  input  logic [7:0]  kbd_data_i,
  input  logic        kbd_valid_i,
  input  logic        dsp_ready_i,
  output logic [15:0] rdata_o,
  output logic        kbd_int_o,
  output logic [7:0]  ddr_data_o,
  output logic        ddr_valid_o
);

  logic       kbsr_rdy_q, kbsr_rdy_d;
  logic       kbsr_ie_q, kbsr_ie_d;
  logic [7:0] kbdr_q, kbdr_d;
  logic       ddr_vld_q, ddr_vld_d;
  logic [7:0] ddr_dat_q, ddr_dat_d;
  logic       unused_mdr;

  // Only bit 14 (interrupt enable) and the low byte are consumed from MDR.
  assign unused_mdr = ^{mdr_i[15], mdr_i[13:8]};

  // Read mux: decoded from the address the access is using.
  always_comb begin
    rdata_o = 16'h0000;
    case (addr_i)
      ADDR_KBSR: rdata_o = {kbsr_rdy_q, kbsr_ie_q, 14'h0000};
      ADDR_KBDR: rdata_o = {8'h00, kbdr_q};
      ADDR_DSR:  rdata_o = {dsp_ready_i, 15'h0000};
      default:   rdata_o = 16'h0000;
    endcase
  end

  // Device register next state; a new key wins over a same-cycle KBDR read clear.
  always_comb begin
    kbsr_rdy_d = kbsr_rdy_q;
    kbsr_ie_d  = kbsr_ie_q;
    kbdr_d     = kbdr_q;
    if (acc_i && !we_i && (addr_i == ADDR_KBDR)) kbsr_rdy_d = 1'b0;
    if (kbd_valid_i) begin
      kbsr_rdy_d = 1'b1;
      kbdr_d     = kbd_data_i;
    end
    if (acc_i && we_i && (addr_i == ADDR_KBSR)) kbsr_ie_d = mdr_i[14];
    ddr_vld_d = acc_i && we_i && (addr_i == ADDR_DDR);
    ddr_dat_d = ddr_vld_d ? mdr_i[7:0] : 8'h00;
  end

  // Register update; the DDR strobe lands exactly on the access's DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      kbsr_rdy_q <= 1'b0;
      kbsr_ie_q  <= 1'b0;
      kbdr_q     <= 8'h00;
      ddr_vld_q  <= 1'b0;
      ddr_dat_q  <= 8'h00;
    end else begin
      kbsr_rdy_q <= kbsr_rdy_d;
      kbsr_ie_q  <= kbsr_ie_d;
      kbdr_q     <= kbdr_d;
      ddr_vld_q  <= ddr_vld_d;
      ddr_dat_q  <= ddr_dat_d;
    end
  end

  assign kbd_int_o   = kbsr_rdy_q & kbsr_ie_q;
  assign ddr_data_o  = ddr_dat_q;
  assign ddr_valid_o = ddr_vld_q;

endmodule

// File: rtl/lc3_mem_if.sv
// LC-3 MAR/MDR memory interface: external req/ack path with timeout, optional devices (LC3_MMIO_EN).
// Latency: external access = 1+ REQ cycles then one DONE cycle; device access goes straight to DONE.
// Backpressure: mem_ack stalls REQ up to MEM_TIMEOUT cycles, after which DONE reports mem_err.
module lc3_mem_if
  import lc3_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bus_in,
  input  logic        ld_mar,
  input  logic        ld_mdr,
  input  logic        mio_en,
  input  logic        r_w,
  output logic [15:0] mdr_out,
  output logic        mem_r,
  output logic        mem_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  input  logic [7:0]  kbd_data,
  input  logic        kbd_valid,
  output logic        kbd_int,
  input  logic        dsp_ready,
  output logic [7:0]  ddr_data,
  output logic        ddr_valid
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [15:0]   mar_q, mar_d;
  logic [15:0]   mdr_q, mdr_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mmio_hit;
  logic [15:0]   mmio_rdata;

`ifdef LC3_MMIO_EN
  logic mmio_acc;

  assign mmio_hit = is_mmio(mar_q);
  assign mmio_acc = (state_q == IDLE) && mio_en && mmio_hit;

  lc3_mmio u_mmio (
    .clk         (clk),
    .rst         (rst),
    .acc_i       (mmio_acc),
    .we_i        (r_w),
    .addr_i      (mar_q),
    .mdr_i       (mdr_q),
    .kbd_data_i  (kbd_data),
    .kbd_valid_i (kbd_valid),
    .dsp_ready_i (dsp_ready),
    .rdata_o     (mmio_rdata),
    .kbd_int_o   (kbd_int),
    .ddr_data_o  (ddr_data),
    .ddr_valid_o (ddr_valid)
  );
`else
  logic unused_dev_in;

  // Without devices every address goes external and device pins are idle.
  assign mmio_hit      = 1'b0;
  assign mmio_rdata    = 16'h0000;
  assign kbd_int       = 1'b0;
  assign ddr_data      = 8'h00;
  assign ddr_valid     = 1'b0;
  assign unused_dev_in = ^{kbd_data, kbd_valid, dsp_ready};
`endif

  // Next-state and outputs; MDR priority is memory/device read over ld_mdr.
  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    we_d    = we_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    mem_r   = 1'b0;
    mem_err = 1'b0;
    if (ld_mdr && !mio_en) mdr_d = bus_in;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        err_d = 1'b0;
        if (ld_mar) mar_d = bus_in;
        if (mio_en) begin
          we_d = r_w;
          if (mmio_hit) begin
            state_d = DONE;
            if (!r_w) mdr_d = mmio_rdata;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        mem_req = 1'b1;
        mem_we  = we_q;
        // An ack on the last allowed cycle still completes without error.
        if (mem_ack) begin
          state_d = DONE;
          if (!we_q) mdr_d = mem_rdata;
        end else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        mem_r   = 1'b1;
        mem_err = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mar_q   <= 16'h0000;
      mdr_q   <= 16'h0000;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      we_q    <= we_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mdr_out   = mdr_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;

endmodule

// File: tb/tb_lc3_mem_if.sv
// Directed bench for lc3_mem_if: external access table plus reset/priority/device sequences.
// Latency: checks sample 1ns after each rising edge.
// Backpressure: every wait on completion is bounded by a cycle budget.
module tb_lc3_mem_if;
  import lc3_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bus_in;
  logic        ld_mar, ld_mdr, mio_en, r_w;
  logic [15:0] mdr_out;
  logic        mem_r, mem_err, mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [7:0]  kbd_data;
  logic        kbd_valid, kbd_int, dsp_ready;
  logic [7:0]  ddr_data;
  logic        ddr_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [15:0] data;
    int          ack_dly;
    logic [15:0] exp_mdr;
    logic        exp_err;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[5];

  lc3_mem_if #(.MEM_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .bus_in(bus_in), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
    .mio_en(mio_en), .r_w(r_w), .mdr_out(mdr_out), .mem_r(mem_r), .mem_err(mem_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .kbd_data(kbd_data), .kbd_valid(kbd_valid),
    .kbd_int(kbd_int), .dsp_ready(dsp_ready), .ddr_data(ddr_data), .ddr_valid(ddr_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mar(input logic [15:0] a);
    bus_in = a; ld_mar = 1'b1;
    tick();
    ld_mar = 1'b0;
  endtask

  task automatic load_mdr(input logic [15:0] d);
    bus_in = d; ld_mdr = 1'b1;
    tick();
    ld_mdr = 1'b0;
  endtask

  // External access: mio_en for one cycle only, ack after ack_dly REQ cycles.
  task automatic run_vec(input vec_t v);
    int  n;
    bit  done;
    load_mar(v.addr);
    if (v.rw) load_mdr(v.data);
    mio_en = 1'b1; r_w = v.rw;
    tick();
    mio_en = 1'b0; r_w = ~v.rw;
    chk("req_on", {31'b0, mem_req}, 32'd1);
    chk("req_we", {31'b0, mem_we}, {31'b0, v.rw});
    chk("req_addr", {16'b0, mem_addr}, {16'b0, v.addr});
    if (v.rw) chk("req_wdata", {16'b0, mem_wdata}, {16'b0, v.data});
    n = 0; done = 1'b0;
    while (!done && n < 200) begin
      if (n == v.ack_dly) begin
        mem_ack = 1'b1; mem_rdata = v.data;
      end
      tick();
      mem_ack = 1'b0; mem_rdata = 16'h0BAD;
      n++;
      if (mem_r) done = 1'b1;
    end
    chk("access_done", {31'b0, done}, 32'd1);
    chk("req_cycles", n, v.exp_cycles);
    chk("done_err", {31'b0, mem_err}, {31'b0, v.exp_err});
    chk("done_mdr", {16'b0, mdr_out}, {16'b0, v.exp_mdr});
    chk("done_req_off", {31'b0, mem_req}, 32'd0);
    tick();
    chk("r_single_pulse", {31'b0, mem_r}, 32'd0);
    r_w = 1'b0;
  endtask

`ifdef LC3_MMIO_EN
  // Device access: completes in DONE right after the mio_en edge, never touching mem_req.
  task automatic mmio_rw(input logic [15:0] a, input logic rw);
    load_mar(a);
    mio_en = 1'b1; r_w = rw;
    tick();
    mio_en = 1'b0; r_w = 1'b0;
    chk("mmio_r", {31'b0, mem_r}, 32'd1);
    chk("mmio_no_req", {31'b0, mem_req}, 32'd0);
  endtask
`endif

  initial begin
    rst = 1'b1; bus_in = 16'h0; ld_mar = 1'b0; ld_mdr = 1'b0; mio_en = 1'b0; r_w = 1'b0;
    mem_rdata = 16'h0; mem_ack = 1'b0; kbd_data = 8'h0; kbd_valid = 1'b0; dsp_ready = 1'b0;

    vecs[0] = '{rw: 1'b0, addr: 16'h3000, data: 16'h1234, ack_dly: 2,
                exp_mdr: 16'h1234, exp_err: 1'b0, exp_cycles: 3};
    vecs[1] = '{rw: 1'b1, addr: 16'h4000, data: 16'hBEEF, ack_dly: 0,
                exp_mdr: 16'hBEEF, exp_err: 1'b0, exp_cycles: 1};
    vecs[2] = '{rw: 1'b0, addr: 16'h5000, data: 16'h9999, ack_dly: 1000,
                exp_mdr: 16'hBEEF, exp_err: 1'b1, exp_cycles: 64};
    vecs[3] = '{rw: 1'b0, addr: 16'h0000, data: 16'hA5A5, ack_dly: 63,
                exp_mdr: 16'hA5A5, exp_err: 1'b0, exp_cycles: 64};
    vecs[4] = '{rw: 1'b1, addr: 16'hFFFF, data: 16'h0001, ack_dly: 5,
                exp_mdr: 16'h0001, exp_err: 1'b0, exp_cycles: 6};

    tick(); tick();
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_r", {31'b0, mem_r}, 32'd0);
    chk("rst_mem_err", {31'b0, mem_err}, 32'd0);
    chk("rst_mdr", {16'b0, mdr_out}, 32'd0);
    chk("rst_mar", {16'b0, mem_addr}, 32'd0);
    chk("rst_kbd_int", {31'b0, kbd_int}, 32'd0);
    chk("rst_ddr_valid", {31'b0, ddr_valid}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Read ack wins over ld_mdr; ld_mar outside IDLE is ignored.
    load_mar(16'h1000);
    mio_en = 1'b1; r_w = 1'b0;
    tick();
    mio_en = 1'b0;
    bus_in = 16'hDEAD; ld_mar = 1'b1; ld_mdr = 1'b1;
    mem_ack = 1'b1; mem_rdata = 16'h5A5A;
    tick();
    ld_mar = 1'b0; ld_mdr = 1'b0; mem_ack = 1'b0;
    chk("prio_mem_r", {31'b0, mem_r}, 32'd1);
    chk("prio_mdr", {16'b0, mdr_out}, 32'h5A5A);
    chk("mar_ignored", {16'b0, mem_addr}, 32'h1000);
    tick();
    load_mdr(16'h1357);
    chk("ld_mdr_idle", {16'b0, mdr_out}, 32'h1357);
    load_mar(16'h2468);
    chk("ld_mar_idle", {16'b0, mem_addr}, 32'h2468);

    // Reset in REQ abandons the access.
    load_mar(16'h3000);
    mio_en = 1'b1; r_w = 1'b0;
    tick();
    mio_en = 1'b0;
    chk("rst_seq_req", {31'b0, mem_req}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_seq_req_off", {31'b0, mem_req}, 32'd0);
    chk("rst_seq_mar", {16'b0, mem_addr}, 32'd0);
    chk("rst_seq_mdr", {16'b0, mdr_out}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    for (int i = 0; i < 4; i++) begin
      chk("rst_seq_no_r", {31'b0, mem_r}, 32'd0);
      tick();
    end
    mem_ack = 1'b0;
    chk("rst_seq_mdr_hold", {16'b0, mdr_out}, 32'd0);

`ifdef LC3_MMIO_EN
    kbd_valid = 1'b1; kbd_data = 8'h41;
    tick();
    kbd_valid = 1'b0;
    mmio_rw(ADDR_KBSR, 1'b0); chk("kbsr_rdy", {16'b0, mdr_out}, 32'h8000); tick();
    mmio_rw(ADDR_KBDR, 1'b0); chk("kbdr_41", {16'b0, mdr_out}, 32'h0041); tick();
    mmio_rw(ADDR_KBSR, 1'b0); chk("kbsr_clr", {16'b0, mdr_out}, 32'h0000); tick();
    load_mdr(16'h4000);
    mmio_rw(ADDR_KBSR, 1'b1); tick();
    chk("kbd_int_off", {31'b0, kbd_int}, 32'd0);
    kbd_valid = 1'b1; kbd_data = 8'h42;
    tick();
    kbd_valid = 1'b0;
    chk("kbd_int_on", {31'b0, kbd_int}, 32'd1);
    mmio_rw(ADDR_KBSR, 1'b0); chk("kbsr_ie_rdy", {16'b0, mdr_out}, 32'hC000); tick();
    // Same-cycle key arrival and KBDR read: ready stays set.
    load_mar(ADDR_KBDR);
    mio_en = 1'b1; r_w = 1'b0; kbd_valid = 1'b1; kbd_data = 8'h43;
    tick();
    mio_en = 1'b0; kbd_valid = 1'b0;
    chk("kbdr_old", {16'b0, mdr_out}, 32'h0042);
    tick();
    chk("set_wins_int", {31'b0, kbd_int}, 32'd1);
    mmio_rw(ADDR_KBSR, 1'b0); chk("set_wins", {16'b0, mdr_out}, 32'hC000); tick();
    load_mdr(16'h00FF);
    mmio_rw(ADDR_KBDR, 1'b1); tick();
    mmio_rw(ADDR_KBDR, 1'b0); chk("kbdr_wr_ignored", {16'b0, mdr_out}, 32'h0043); tick();
    load_mdr(16'h0058);
    mmio_rw(ADDR_DDR, 1'b1);
    chk("ddr_valid", {31'b0, ddr_valid}, 32'd1);
    chk("ddr_data", {24'b0, ddr_data}, 32'h58);
    tick();
    chk("ddr_valid_off", {31'b0, ddr_valid}, 32'd0);
    chk("ddr_no_req", {31'b0, mem_req}, 32'd0);
    dsp_ready = 1'b1;
    mmio_rw(ADDR_DSR, 1'b0); chk("dsr_ready", {16'b0, mdr_out}, 32'h8000); tick();
    dsp_ready = 1'b0;
    mmio_rw(ADDR_DSR, 1'b0); chk("dsr_busy", {16'b0, mdr_out}, 32'h0000); tick();
`else
    // Without devices, the DDR address is an ordinary external write.
    run_vec('{rw: 1'b1, addr: 16'hFE06, data: 16'h0058, ack_dly: 1,
              exp_mdr: 16'h0058, exp_err: 1'b0, exp_cycles: 2});
    chk("no_ddr_valid", {31'b0, ddr_valid}, 32'd0);
    chk("no_ddr_data", {24'b0, ddr_data}, 32'd0);
    run_vec('{rw: 1'b0, addr: 16'hFE00, data: 16'h8001, ack_dly: 0,
              exp_mdr: 16'h8001, exp_err: 1'b0, exp_cycles: 1});
    kbd_valid = 1'b1; kbd_data = 8'h41;
    tick();
    kbd_valid = 1'b0;
    chk("no_kbd_int", {31'b0, kbd_int}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
